// File: rtl/ttt_board.sv
// Tic-tac-toe core: PS/2 set-2 decoder, cursor and mark state, and a one-clock-latency board renderer.
// Define TTT_WRAP_EN to make the cursor wrap at the board edges; otherwise it saturates at 0 and 2.
module ttt_board (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [7:0]  iScan_Code,
  input  logic        iScan_Valid,
  input  logic [9:0]  iPx,
  input  logic [9:0]  iPy,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic [17:0] oSquare,
  output logic [1:0]  oPlayer,
  output logic [1:0]  oCursor_Col,
  output logic [1:0]  oCursor_Row
);

  logic        r_ext, r_brk;
  logic [17:0] r_square;
  logic [1:0]  r_player, r_col, r_row;
  logic [9:0]  r_red, r_green, r_blue;

  logic        w_ext, w_brk;
  logic [17:0] w_square;
  logic [1:0]  w_player, w_col, w_row;
  logic [3:0]  w_k;
  logic [4:0]  w_shift;
  logic [1:0]  w_cur_cell;
  logic [17:0] w_mark;

  function automatic logic [1:0] f_inc(input logic [1:0] v);
`ifdef TTT_WRAP_EN
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
`else
    return (v == 2'd2) ? 2'd2 : v + 2'd1;
`endif
  endfunction

  function automatic logic [1:0] f_dec(input logic [1:0] v);
`ifdef TTT_WRAP_EN
    return (v == 2'd0) ? 2'd2 : v - 2'd1;
`else
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
`endif
  endfunction

  // Cell k lives at bits [17-2k:16-2k], i.e. shift right by 16-2k.
  assign w_k        = {2'b00, r_row} * 4'd3 + {2'b00, r_col};
  assign w_shift    = 5'd16 - {w_k, 1'b0};
  assign w_cur_cell = 2'(r_square >> w_shift);
  assign w_mark     = {16'b0, r_player} << w_shift;

  always_comb begin
    w_ext    = r_ext;
    w_brk    = r_brk;
    w_square = r_square;
    w_player = r_player;
    w_col    = r_col;
    w_row    = r_row;
    if (iScan_Valid) begin
      if (iScan_Code == 8'hE0) begin
        w_ext = 1'b1;
      end else if (iScan_Code == 8'hF0) begin
        w_brk = 1'b1;
      end else begin
        w_ext = 1'b0;
        w_brk = 1'b0;
        if (!r_brk) begin
          if (r_ext) begin
            case (iScan_Code)
              8'h74:   w_col = f_inc(r_col);
              8'h6B:   w_col = f_dec(r_col);
              8'h75:   w_row = f_inc(r_row);
              8'h72:   w_row = f_dec(r_row);
              default: ;
            endcase
          end else begin
            case (iScan_Code)
              8'h2D: begin
                w_square = '0;
                w_player = 2'd1;
                w_col    = 2'd0;
                w_row    = 2'd0;
              end
              8'h29: begin
                if (w_cur_cell == 2'd0) begin
                  w_square = r_square | w_mark;
                  w_player = (r_player == 2'd1) ? 2'd2 : 2'd1;
                end
              end
              8'h5A: begin
                if (w_cur_cell == 2'd0) w_square = r_square | w_mark;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_ext    <= 1'b0;
      r_brk    <= 1'b0;
      r_square <= '0;
      r_player <= 2'd1;
      r_col    <= 2'd0;
      r_row    <= 2'd0;
    end else begin
      r_ext    <= w_ext;
      r_brk    <= w_brk;
      r_square <= w_square;
      r_player <= w_player;
      r_col    <= w_col;
      r_row    <= w_row;
    end
  end

  logic        w_in_board, w_grid, w_cursor, w_xmark, w_omark;
  logic [1:0]  w_pcol, w_prow, w_pcell;
  logic [3:0]  w_pk;
  logic [4:0]  w_pshift;
  logic [7:0]  w_lx, w_ly, w_d1;
  logic [8:0]  w_sum, w_d2;
  logic [6:0]  w_dx, w_dy;
  logic [12:0] w_sqx, w_sqy;
  logic [13:0] w_r2;

  assign w_in_board = (iPx < 10'd480) && (iPy < 10'd480);
  assign w_pcol = (iPx < 10'd160) ? 2'd0 : (iPx < 10'd320) ? 2'd1 : 2'd2;
  assign w_prow = (iPy < 10'd160) ? 2'd0 : (iPy < 10'd320) ? 2'd1 : 2'd2;
  assign w_lx   = 8'(iPx - ((w_pcol == 2'd0) ? 10'd0 : (w_pcol == 2'd1) ? 10'd160 : 10'd320));
  assign w_ly   = 8'(iPy - ((w_prow == 2'd0) ? 10'd0 : (w_prow == 2'd1) ? 10'd160 : 10'd320));

  assign w_pk     = {2'b00, w_prow} * 4'd3 + {2'b00, w_pcol};
  assign w_pshift = 5'd16 - {w_pk, 1'b0};
  assign w_pcell  = 2'(r_square >> w_pshift);

  assign w_grid = ((iPx >= 10'd158) && (iPx <= 10'd161)) || ((iPx >= 10'd318) && (iPx <= 10'd321)) ||
                  ((iPy >= 10'd158) && (iPy <= 10'd161)) || ((iPy >= 10'd318) && (iPy <= 10'd321));

  assign w_cursor = (w_pcol == r_col) && (w_prow == r_row) &&
                    (w_lx >= 8'd70) && (w_lx <= 8'd89) && (w_ly >= 8'd70) && (w_ly <= 8'd89);

  // Two diagonals of half-width 3 inside a 120x120 box centred in the cell.
  assign w_d1  = (w_lx >= w_ly) ? (w_lx - w_ly) : (w_ly - w_lx);
  assign w_sum = {1'b0, w_lx} + {1'b0, w_ly};
  assign w_d2  = (w_sum >= 9'd159) ? (w_sum - 9'd159) : (9'd159 - w_sum);
  assign w_xmark = (w_pcell == 2'd1) &&
                   (w_lx >= 8'd20) && (w_lx <= 8'd139) && (w_ly >= 8'd20) && (w_ly <= 8'd139) &&
                   ((w_d1 <= 8'd3) || (w_d2 <= 9'd3));

  // Individual squares fit 13 bits; the sum is kept one bit wider so cell corners cannot alias into the ring.
  assign w_dx  = 7'((w_lx >= 8'd80) ? (w_lx - 8'd80) : (8'd80 - w_lx));
  assign w_dy  = 7'((w_ly >= 8'd80) ? (w_ly - 8'd80) : (8'd80 - w_ly));
  assign w_sqx = {6'b0, w_dx} * {6'b0, w_dx};
  assign w_sqy = {6'b0, w_dy} * {6'b0, w_dy};
  assign w_r2  = {1'b0, w_sqx} + {1'b0, w_sqy};
  assign w_omark = (w_pcell == 2'd2) && (w_r2 >= 14'd2500) && (w_r2 <= 14'd3136);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (!w_in_board || w_grid) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (w_cursor) begin
      r_red   <= '0;
      r_green <= 10'h3FF;
      r_blue  <= '0;
    end else if (w_xmark) begin
      r_red   <= 10'h3FF;
      r_green <= '0;
      r_blue  <= '0;
    end else if (w_omark) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= 10'h3FF;
    end else begin
      r_red   <= 10'h3FF;
      r_green <= 10'h3FF;
      r_blue  <= 10'h3FF;
    end
  end

  assign oRed        = r_red;
  assign oGreen      = r_green;
  assign oBlue       = r_blue;
  assign oSquare     = r_square;
  assign oPlayer     = r_player;
  assign oCursor_Col = r_col;
  assign oCursor_Row = r_row;

endmodule

// File: tb/tb_ttt_board.sv
// Directed bench for ttt_board: expected values queued as stimulus is driven, popped when outputs are sampled.
module tb_ttt_board;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [7:0]  iScan_Code;
  logic        iScan_Valid;
  logic [9:0]  iPx, iPy;
  logic [9:0]  oRed, oGreen, oBlue;
  logic [17:0] oSquare;
  logic [1:0]  oPlayer, oCursor_Col, oCursor_Row;

  ttt_board dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iScan_Code(iScan_Code), .iScan_Valid(iScan_Valid),
    .iPx(iPx), .iPy(iPy), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oSquare(oSquare), .oPlayer(oPlayer), .oCursor_Col(oCursor_Col), .oCursor_Row(oCursor_Row)
  );

  always #5 iCLK = ~iCLK;

  localparam logic [29:0] BLACK = 30'h0;
  localparam logic [29:0] WHITE = 30'h3FFFFFFF;
  localparam logic [29:0] RED   = 30'h3FF00000;
  localparam logic [29:0] GREEN = 30'h000FFC00;
  localparam logic [29:0] BLUE  = 30'h000003FF;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic push_exp(input string tag, input logic [31:0] e);
    exp_t t;
    t.tag = tag;
    t.exp = e;
    sb.push_back(t);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t t;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty observed=%h expected=<queued value>", obs);
      return;
    end
    t = sb.pop_front();
    vectors++;
    assert (obs === t.exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", t.tag, obs, t.exp);
    end
  endtask

  task automatic exp_state(input logic [1:0] col, input logic [1:0] row,
                           input logic [1:0] ply, input logic [17:0] sq);
    push_exp("cursor_col", {30'b0, col});
    push_exp("cursor_row", {30'b0, row});
    push_exp("player",     {30'b0, ply});
    push_exp("square",     {14'b0, sq});
  endtask

  task automatic cmp_state();
    pop_cmp({30'b0, oCursor_Col});
    pop_cmp({30'b0, oCursor_Row});
    pop_cmp({30'b0, oPlayer});
    pop_cmp({14'b0, oSquare});
  endtask

  // Consecutive calls produce back-to-back strobes; idle() ends the burst.
  task automatic send(input logic [7:0] b);
    @(negedge iCLK);
    iScan_Code  = b;
    iScan_Valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge iCLK);
    iScan_Valid = 1'b0;
    iScan_Code  = 8'h00;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [29:0] rgb);
    @(negedge iCLK);
    iPx = x;
    iPy = y;
    push_exp("rgb", {2'b00, rgb});
    @(negedge iCLK);
    pop_cmp({2'b00, oRed, oGreen, oBlue});
  endtask

  initial begin
    iRST_N      = 1'b1;
    iScan_Code  = 8'h00;
    iScan_Valid = 1'b0;
    iPx         = 10'd0;
    iPy         = 10'd0;
    #2 iRST_N = 1'b0;
    #1;
    exp_state(2'd0, 2'd0, 2'd1, 18'h0);
    cmp_state();

    // Renderer held black while in reset, even over the cursor.
    pix(10'd75, 10'd75, BLACK);
    @(negedge iCLK);
    iRST_N = 1'b1;

    pix(10'd75,  10'd75, GREEN);
    pix(10'd159, 10'd10, BLACK);
    pix(10'd10,  10'd10, WHITE);
    pix(10'd600, 10'd10, BLACK);

    send(8'hE0); send(8'h74); send(8'hE0); send(8'h74); send(8'h29); idle();
    exp_state(2'd2, 2'd0, 2'd2, 18'h01000);
    cmp_state();
    pix(10'd340, 10'd20, RED);

    send(8'h29); idle();
    exp_state(2'd2, 2'd0, 2'd2, 18'h01000);
    cmp_state();

    send(8'hE0); send(8'h72); idle();
`ifdef TTT_WRAP_EN
    exp_state(2'd2, 2'd2, 2'd2, 18'h01000);
    cmp_state();
    send(8'hE0); send(8'h72); send(8'hE0); send(8'h6B); idle();
`else
    exp_state(2'd2, 2'd0, 2'd2, 18'h01000);
    cmp_state();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h6B); idle();
`endif
    exp_state(2'd1, 2'd1, 2'd2, 18'h01000);
    cmp_state();

    send(8'h5A); idle();
    exp_state(2'd1, 2'd1, 2'd2, 18'h01200);
    cmp_state();

    send(8'hF0); send(8'h5A); idle();
    exp_state(2'd1, 2'd1, 2'd2, 18'h01200);
    cmp_state();

    send(8'hF0); send(8'h29); idle();
    exp_state(2'd1, 2'd1, 2'd2, 18'h01200);
    cmp_state();

    // Flags must be clear after the release sequence: extended move acts normally.
    send(8'hE0); send(8'h74); idle();
    exp_state(2'd2, 2'd1, 2'd2, 18'h01200);
    cmp_state();

    send(8'h2D); idle();
    exp_state(2'd0, 2'd0, 2'd1, 18'h0);
    cmp_state();

    // X at (0,1), then O at (0,0) via enter, then park cursor on (0,1).
    send(8'hE0); send(8'h74); send(8'h29);
    send(8'hE0); send(8'h6B); send(8'h5A);
    send(8'hE0); send(8'h74); idle();
    exp_state(2'd1, 2'd0, 2'd2, 18'h24000);
    cmp_state();

    pix(10'd130, 10'd80, BLUE);
    pix(10'd80,  10'd80, WHITE);
    pix(10'd240, 10'd80, GREEN);
    pix(10'd180, 10'd20, RED);
    pix(10'd80,  10'd133, BLUE);

    @(negedge iCLK);
    #2 iRST_N = 1'b0;
    #1;
    exp_state(2'd0, 2'd0, 2'd1, 18'h0);
    cmp_state();
    push_exp("rgb_reset", 32'h0);
    pop_cmp({2'b00, oRed, oGreen, oBlue});
    @(negedge iCLK);
    iRST_N = 1'b1;

    if (sb.size() != 0) begin
      miscompares++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ttt_board.md
# ttt_board

Tic-tac-toe game core for the VGA demo top level. It consumes PS/2 set-2 scan-code bytes and maintains the cursor, the 3×3 mark array and the current player. It also renders the board as 10-bit RGB for the pixel coordinate supplied by the VGA sync generator. It sits between the keyboard receiver and vga_sync.

## Interface
- No parameters.
- iCLK  in  1  pixel/system clock; all state and outputs registered on its rising edge.
- iRST_N  in  1  asynchronous, active-low reset.
- iScan_Code  in  8  scan-code byte from the keyboard receiver.
- iScan_Valid  in  1  one-cycle strobe; iScan_Code is valid when high.
- iPx, iPy  in  10 each  current pixel coordinate (0..639, 0..479).
- oRed, oGreen, oBlue  out  10 each  pixel colour for the previous cycle's iPx/iPy.
- oSquare  out  18  mark array; cell k = row*3+col at bits [17-2k:16-2k]; 0 = empty, 1 = X, 2 = O, 3 never written.
- oPlayer  out  2  player to move (1 or 2).
- oCursor_Col, oCursor_Row  out  2 each  cursor cell (0..2).

## Operation
- **Reset values (async, iRST_N=0):** oSquare=0, oPlayer=1, cursor=(0,0), decoder flags clear, RGB=0.
- **Decoder flags:** `ext` is set by byte E0. `brk` is set by byte F0.
- **Byte handling:**
  - E0 or F0: set the matching flag; no action.
  - Any other byte with brk=1: ignored (key release); clears both flags.
  - Otherwise the byte is acted on, then both flags clear.
- **Actions (brk=0):**
  - ext=1, 74: col+1. ext=1, 6B: col−1. ext=1, 75: row+1. ext=1, 72: row−1.
  - ext=0, 2D ('R'): new game; same values as reset, except RGB is unaffected.
  - ext=0, 29 (space): if the cursor cell is empty, write oPlayer into it and toggle the player 1↔2. If the cell is occupied, nothing happens.
  - ext=0, 5A (enter): if the cursor cell is empty, write oPlayer into it; the player is not toggled.
  - All other bytes: no action.
- **Edge movement:** wrap or saturate, selected by the Configuration section.
- **Rendering:**
  - Board area: x<480, y<480. Cell col=x/160, row=y/160; local lx=x−160·col, ly=y−160·row.
  - Colour priority is:
    1. Outside the board area: black.
    2. Grid line (x or y in 158..161 or 318..321): black (0,0,0).
    3. Cursor: cell equals the cursor cell and lx,ly both in 70..89 → green (0,3FF,0).
    4. X mark (cell=1), red (3FF,0,0): lx,ly both in 20..139 and (|lx−ly|≤3 or |lx+ly−159|≤3).
    5. O mark (cell=2), blue (0,0,3FF): 50² ≤ (lx−80)²+(ly−80)² ≤ 56². Squares use unsigned 13-bit arithmetic, compared against 2500 and 3136.
    6. Otherwise: white (3FF,3FF,3FF).

## Timing
- A scan byte takes effect one clock after its iScan_Valid strobe; outputs update on that edge.
- Only one byte is processed per strobe. Back-to-back strobes on consecutive cycles are all processed.
- RGB latency is exactly 1 clock from iPx/iPy. Render logic reads the current registered state, so a move is visible on the next pixel.
- Reset asserted mid-game clears everything immediately. A strobe coincident with reset release is ignored.

## Configuration
- **TTT_WRAP_EN defined:** cursor wraps at the edges (col 2 → right → 0; col 0 → left → 2; rows likewise).
- **TTT_WRAP_EN undefined:** cursor saturates at 0 and 2.

## Test plan
- Reset, then drive pixel (75,75) → next cycle RGB=(0,3FF,0) (cursor). Drive (159,10) → (0,0,0). Drive (10,10) → white.
- Bytes E0 74, E0 74, then 29 → oCursor_Col=2; oSquare bits [13:12]=1; oPlayer=2. Pixel (340,20) → red (X diagonal at lx=ly=20).
- With the cursor on an occupied cell, send 29 → oSquare and oPlayer unchanged. Then send E0 72 with TTT_WRAP_EN defined → row=2. Undefined → row stays 0.
- Send 5A on empty cell (1,1) → oSquare[9:8]=oPlayer and the player is unchanged. Send F0 5A → no change.
- Send F0 29 (space release) → ignored. Send 2D → oSquare=0, oPlayer=1, cursor (0,0).
- Place O at (0,0) and render pixel (130,80) → blue (distance 50). Render pixel (80,80) → white.
